lcd_bus_monitor: RTL and testbench

Receive-side model of the HD44780-style parallel LCD write bus driven by `lcd_driver`. Samples `lcd_rs`, `lcd_en` and `lcd_data_bus`, qualifies each enable pulse, and decodes it as a command or a character write. Maintains the DDRAM address counter and a busy timer, and flags protocol violations. It is used in simulation benches and in on-chip loopback self-test, connected directly to the `lcd_driver` outputs in the same clock domain.

---
 rtl/lcd_bus_monitor.sv | 179 +++++++++++++++++
 tb/tb_lcd_bus_monitor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_monitor.sv
// Receive-side monitor for an HD44780-style parallel LCD write bus.
// Qualifies each enable pulse, decodes it as a command or character write,
// tracks the DDRAM address counter and busy timer, and flags protocol errors.
module lcd_bus_monitor #(
  parameter int unsigned MIN_EN_CYCLES   = 12,
  parameter int unsigned CMD_BUSY_CYCLES = 1850,
  parameter int unsigned CLR_BUSY_CYCLES = 76000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_en,
  input  logic [7:0] lcd_data_bus,
  output logic       cmd_valid,
  output logic       char_valid,
  output logic [7:0] rx_byte,
  output logic [6:0] char_addr,
  output logic [6:0] ddram_addr,
  output logic       display_on,
  output logic       mode_8bit,
  output logic       busy,
  output logic       err_short_pulse,
  output logic       err_busy_write
);

  localparam int unsigned WW       = $clog2(MIN_EN_CYCLES + 1);
  localparam int unsigned BUSY_MAX = (CLR_BUSY_CYCLES > CMD_BUSY_CYCLES) ?
                                     CLR_BUSY_CYCLES : CMD_BUSY_CYCLES;
  localparam int unsigned BW       = $clog2(BUSY_MAX + 1);

  typedef enum logic [1:0] {IDLE, HIGH, COMMIT} state_t;

  state_t          state, state_nxt;
  logic            en_q, rs_q;
  logic [7:0]      data_q;
  logic            arm;
  logic [WW-1:0]   width, width_nxt;
  logic            lat_rs;
  logic [7:0]      lat_data;
  logic [BW-1:0]   busy_cnt;
  logic            id_inc;

  assign busy = (busy_cnt != '0);

  // Single input register stage for the bus signals
  always_ff @(posedge clk) begin
    en_q   <= lcd_en;
    rs_q   <= lcd_rs;
    data_q <= lcd_data_bus;
  end

  // After reset, wait for enable to be seen low so a pulse straddling reset is dropped
  always_ff @(posedge clk) begin
    if (!rst)       arm <= 1'b0;
    else if (!en_q) arm <= 1'b1;
  end

  // State and pulse-width registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      width <= '0;
    end else begin
      state <= state_nxt;
      width <= width_nxt;
    end
  end

  // Next-state: measure enable width, saturating at the minimum.
  // COMMIT starts a new pulse directly so a one-cycle gap loses no width.
  always_comb begin
    state_nxt = state;
    width_nxt = width;
    case (state)
      IDLE: begin
        if (en_q && arm) begin
          state_nxt = HIGH;
          width_nxt = WW'(1);
        end
      end
      HIGH: begin
        if (en_q) begin
          if (width < WW'(MIN_EN_CYCLES)) width_nxt = width + WW'(1);
        end else begin
          state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        if (en_q && arm) begin
          state_nxt = HIGH;
          width_nxt = WW'(1);
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture RS and data on every high cycle; the last one wins
  always_ff @(posedge clk) begin
    if (!rst) begin
      lat_rs   <= 1'b0;
      lat_data <= '0;
    end else if (en_q) begin
      lat_rs   <= rs_q;
      lat_data <= data_q;
    end
  end

  // Commit: validate the pulse, decode it, update address/mode state and busy timer
  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_valid       <= 1'b0;
      char_valid      <= 1'b0;
      rx_byte         <= '0;
      char_addr       <= '0;
      ddram_addr      <= '0;
      display_on      <= 1'b0;
      mode_8bit       <= 1'b0;
      err_short_pulse <= 1'b0;
      err_busy_write  <= 1'b0;
      busy_cnt        <= '0;
      id_inc          <= 1'b1;
    end else begin
      cmd_valid  <= 1'b0;
      char_valid <= 1'b0;
      if (busy_cnt != '0) busy_cnt <= busy_cnt - BW'(1);
      if (state == COMMIT) begin
        if (width < WW'(MIN_EN_CYCLES)) begin
          err_short_pulse <= 1'b1;
        end else if (busy) begin
          err_busy_write <= 1'b1;
        end else begin
          rx_byte <= lat_data;
          if (lat_rs) begin
            char_valid <= 1'b1;
            char_addr  <= ddram_addr;
            ddram_addr <= id_inc ? ddram_addr + 7'd1 : ddram_addr - 7'd1;
            busy_cnt   <= BW'(CMD_BUSY_CYCLES);
          end else begin
            cmd_valid <= 1'b1;
            casez (lat_data)
              8'b1???_????: begin
                ddram_addr <= lat_data[6:0];
                busy_cnt   <= BW'(CMD_BUSY_CYCLES);
              end
              8'b01??_????: busy_cnt <= BW'(CMD_BUSY_CYCLES);
              8'b001?_????: begin
                mode_8bit <= lat_data[4];
                busy_cnt  <= BW'(CMD_BUSY_CYCLES);
              end
              8'b0001_????: busy_cnt <= BW'(CMD_BUSY_CYCLES);
              8'b0000_1???: begin
                display_on <= lat_data[2];
                busy_cnt   <= BW'(CMD_BUSY_CYCLES);
              end
              8'b0000_01??: begin
                id_inc   <= lat_data[1];
                busy_cnt <= BW'(CMD_BUSY_CYCLES);
              end
              8'b0000_001?: begin
                ddram_addr <= '0;
                busy_cnt   <= BW'(CLR_BUSY_CYCLES);
              end
              8'b0000_0001: begin
                ddram_addr <= '0;
                id_inc     <= 1'b1;
                busy_cnt   <= BW'(CLR_BUSY_CYCLES);
              end
              default: ; // 0x00: acknowledged, no effect, no busy
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Self-checking bench for lcd_bus_monitor: directed and random writes checked
// against a spec-level model of commit timing, decode and busy windows.
module tb_lcd_bus_monitor;

  localparam int MIN  = 12;
  localparam int CMDB = 20;
  localparam int CLRB = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lcd_rs = 1'b0;
  logic       lcd_en = 1'b0;
  logic [7:0] lcd_data_bus = '0;
  logic       cmd_valid, char_valid, display_on, mode_8bit, busy;
  logic       err_short_pulse, err_busy_write;
  logic [7:0] rx_byte;
  logic [6:0] char_addr, ddram_addr;

  lcd_bus_monitor #(
    .MIN_EN_CYCLES  (MIN),
    .CMD_BUSY_CYCLES(CMDB),
    .CLR_BUSY_CYCLES(CLRB)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .lcd_rs         (lcd_rs),
    .lcd_en         (lcd_en),
    .lcd_data_bus   (lcd_data_bus),
    .cmd_valid      (cmd_valid),
    .char_valid     (char_valid),
    .rx_byte        (rx_byte),
    .char_addr      (char_addr),
    .ddram_addr     (ddram_addr),
    .display_on     (display_on),
    .mode_8bit      (mode_8bit),
    .busy           (busy),
    .err_short_pulse(err_short_pulse),
    .err_busy_write (err_busy_write)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         c;
    bit         cv, chv, disp, m8, esp, ebw;
    logic [7:0] rx;
    logic [6:0] caddr, addr;
  } ev_t;

  ev_t        evq[$];
  logic [6:0] m_addr, m_caddr;
  logic [7:0] m_rx;
  bit         m_id, m_disp, m_8, m_esp, m_ebw;
  int         bs, be, pbs, pbe;  // current and previous busy windows [start, end)

  function automatic bit busy_at(input int c);
    return (c >= bs && c < be) || (c >= pbs && c < pbe);
  endfunction

  task automatic model_reset();
    m_addr = '0; m_caddr = '0; m_rx = '0;
    m_id = 1'b1; m_disp = 1'b0; m_8 = 1'b0; m_esp = 1'b0; m_ebw = 1'b0;
    bs = 0; be = 0; pbs = 0; pbe = 0;
    evq.delete();
  endtask

  // Predict the outcome of a write whose commit lands on clock edge c
  task automatic model_commit(input int c, input bit rs, input logic [7:0] d, input int w);
    ev_t e;
    int  b;
    int  dv;
    b = 0;
    dv = int'(d);
    e.cv = 1'b0; e.chv = 1'b0;
    if (w < MIN) m_esp = 1'b1;
    else if (busy_at(c - 1)) m_ebw = 1'b1;
    else begin
      m_rx = d;
      if (rs) begin
        e.chv   = 1'b1;
        m_caddr = m_addr;
        m_addr  = 7'((int'(m_addr) + (m_id ? 1 : 127)) % 128);
        b = CMDB;
      end else begin
        e.cv = 1'b1;
        if (dv == 1) begin m_addr = '0; m_id = 1'b1; b = CLRB; end
        else if (dv == 2 || dv == 3) begin m_addr = '0; b = CLRB; end
        else if (dv >= 4) begin
          b = CMDB;
          if (dv < 8) m_id = d[1];
          else if (dv < 16) m_disp = d[2];
          else if (dv >= 32 && dv < 64) m_8 = d[4];
          else if (dv >= 128) m_addr = 7'(dv % 128);
        end
      end
      if (b > 0) begin pbs = bs; pbe = be; bs = c; be = c + b; end
    end
    e.c = c; e.rx = m_rx; e.caddr = m_caddr; e.addr = m_addr;
    e.disp = m_disp; e.m8 = m_8; e.esp = m_esp; e.ebw = m_ebw;
    evq.push_back(e);
  endtask

  // Per-cycle monitor: busy window, valid pulses only where the model expects them
  always @(negedge clk) begin
    if (rst) begin
      check_eq("busy", busy, busy_at(cyc));
      if (evq.size() > 0 && evq[0].c < cyc) begin
        check_eq("commit missed", 32'(cyc), 32'(evq[0].c));
        void'(evq.pop_front());
      end
      if (evq.size() > 0 && evq[0].c == cyc) begin
        ev_t e;
        e = evq.pop_front();
        check_eq("cmd_valid", cmd_valid, e.cv);
        check_eq("char_valid", char_valid, e.chv);
        check_eq("rx_byte", rx_byte, e.rx);
        check_eq("char_addr", char_addr, e.caddr);
        check_eq("ddram_addr", ddram_addr, e.addr);
        check_eq("display_on", display_on, e.disp);
        check_eq("mode_8bit", mode_8bit, e.m8);
        check_eq("err_short_pulse", err_short_pulse, e.esp);
        check_eq("err_busy_write", err_busy_write, e.ebw);
      end else begin
        check_eq("cmd_valid quiet", cmd_valid, 1'b0);
        check_eq("char_valid quiet", char_valid, 1'b0);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Drive one enable pulse of w high cycles (data settles only in the last one),
  // then hold enable low for low_after cycles with garbage on the bus.
  task automatic do_pulse(input bit rs, input logic [7:0] d, input int w, input int low_after);
    for (int i = 0; i < w; i++) begin
      lcd_en = 1'b1;
      if (i == w - 1) begin
        lcd_rs = rs; lcd_data_bus = d;
      end else begin
        lcd_rs = 1'($urandom_range(0, 1)); lcd_data_bus = 8'($urandom);
      end
      @(negedge clk);
    end
    lcd_en = 1'b0;
    model_commit(cyc + 3, rs, d, w);
    lcd_rs = 1'($urandom_range(0, 1));
    lcd_data_bus = 8'($urandom);
    repeat (low_after) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst cmd_valid", cmd_valid, 1'b0);
    check_eq("rst char_valid", char_valid, 1'b0);
    check_eq("rst rx_byte", rx_byte, 8'h00);
    check_eq("rst char_addr", char_addr, 7'h00);
    check_eq("rst ddram_addr", ddram_addr, 7'h00);
    check_eq("rst display_on", display_on, 1'b0);
    check_eq("rst mode_8bit", mode_8bit, 1'b0);
    check_eq("rst busy", busy, 1'b0);
    check_eq("rst err_short", err_short_pulse, 1'b0);
    check_eq("rst err_busy", err_busy_write, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    check_reset_outputs();
    repeat (3) @(negedge clk);

    // Function set, 25-cycle pulse
    do_pulse(1'b0, 8'h38, 25, 30);
    check_eq("fs mode_8bit", mode_8bit, 1'b1);
    check_eq("fs rx_byte", rx_byte, 8'h38);

    // Clear, then character write
    do_pulse(1'b0, 8'h01, 12, 60);
    do_pulse(1'b1, 8'h54, 12, 25);
    check_eq("cw char_addr", char_addr, 7'h00);
    check_eq("cw ddram_addr", ddram_addr, 7'h01);
    check_eq("cw rx_byte", rx_byte, 8'h54);

    // Address wrap upward, then decrement mode wrap downward
    do_pulse(1'b0, 8'hFF, 12, 25);
    do_pulse(1'b1, 8'h41, 12, 25);
    check_eq("wrap char_addr", char_addr, 7'h7F);
    check_eq("wrap ddram_addr", ddram_addr, 7'h00);
    do_pulse(1'b0, 8'h04, 12, 25);
    do_pulse(1'b1, 8'h42, 12, 25);
    check_eq("dec ddram_addr", ddram_addr, 7'h7F);

    // Short pulse, then a minimum-width pulse
    do_pulse(1'b1, 8'h31, 11, 3);
    check_eq("short err", err_short_pulse, 1'b1);
    do_pulse(1'b1, 8'h32, 12, 25);

    // Write while busy after clear
    do_pulse(1'b0, 8'h01, 12, 1);
    do_pulse(1'b0, 8'h0C, 12, 5);
    check_eq("bw err", err_busy_write, 1'b1);
    check_eq("bw display_on", display_on, 1'b0);
    repeat (60) @(negedge clk);

    // Back-to-back pulses with a single low cycle between them
    do_pulse(1'b1, 8'h33, 5, 1);
    do_pulse(1'b0, 8'h00, 14, 1);
    do_pulse(1'b1, 8'h34, 14, 30);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic [7:0] d;
      bit         rs;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       d = 8'($urandom_range(0, 15));
        1:       d = 8'($urandom_range(0, 63));
        default: d = 8'($urandom);
      endcase
      do_pulse(rs, d, $urandom_range(9, 18), $urandom_range(1, 60));
    end
    repeat (60) @(negedge clk);

    // Reset asserted and released mid-pulse
    lcd_rs = 1'b1; lcd_data_bus = 8'h41; lcd_en = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    lcd_en = 1'b0;
    repeat (10) @(negedge clk);
    check_reset_outputs();

    // Normal write after recovery
    do_pulse(1'b1, 8'h43, 12, 25);
    check_eq("post-rst char_addr", char_addr, 7'h00);
    check_eq("post-rst ddram_addr", ddram_addr, 7'h01);

    check_eq("pending commits", 32'(evq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
